datapath_sequencer: RTL and testbench
=====================================

// Module: datapath_sequencer
// PURPOSE
//  Self-sequenced register-file / ALU / RAM datapath with parametrised width and depth.
//  Accepts one command per valid/ready handshake and steps it through READ, EXEC, MEM and WB
//  states itself, so the caller no longer drives per-cycle selects and write strobes.
//  Sits between the command source (test controller / future decoder) and the data store.
// PARAMETERS
//  DATA_W     64   datapath width in bits; must be at least 8
//  REG_N      32   register count (power of 2); RA_W = log2(REG_N)
//  RAM_DEPTH  256  data RAM words (power of 2); AW = log2(RAM_DEPTH)
// PORTS
//  clk         in   1       clock; all state updates on the rising edge
//  rst         in   1       asynchronous, active-low reset
//  cmd_valid   in   1       command present
//  cmd_ready   out  1       block can accept a command (1 only in IDLE)
//  cmd_mode    in   2       0=ALU 1=LOAD 2=STORE 3=LDI
//  cmd_fn      in   3       0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 PASSB
//  cmd_carry   in   1       carry-in, used by ADD only
//  cmd_sel_a   in   RA_W    operand A register
//  cmd_sel_b   in   RA_W    operand B register
//  cmd_sel_d   in   RA_W    destination register (ALU/LOAD/LDI) or store-data register (STORE)
//  cmd_imm     in   DATA_W  immediate value for LDI
//  busy        out  1       command in flight (~cmd_ready)
//  done        out  1       one-cycle pulse in the WB cycle
//  result      out  DATA_W  value written to the register or RAM; held until the next done
//  flags       out  4       {V,C,N,Z} from the last ALU-mode command; held otherwise
//  err         out  1       address error on the last LOAD/STORE; valid with done, then held
// BEHAVIOUR
//  Reset (rst=0, async):
//   - FSM goes to IDLE; all registers cleared to 0.
//   - Outputs: cmd_ready=1, busy=0, done=0, result=0, flags=0, err=0.
//   - RAM contents are not reset.
//   - An in-flight command is dropped with no register or RAM write.
//  Handshake: a command is accepted on the edge where cmd_valid & cmd_ready; all cmd_* fields
//   are latched on that edge. cmd_ready stays low until the cycle after WB.
//  FSM states: IDLE, READ, EXEC, MEM, WB.
//   - IDLE -> READ on accept; IDLE -> WB if mode=LDI.
//   - READ: latch R[a], R[b] and R[d].
//   - EXEC: latch ALU result and flags. Next state is MEM for LOAD/STORE, otherwise WB.
//   - MEM: synchronous RAM read or write at addr = alu[AW-1:0].
//   - WB: register write; done=1 for this cycle; next state is IDLE.
//  Latency (accept edge = T): done is high in cycle T+1 (LDI), T+3 (ALU), T+4 (LOAD/STORE).
//  R0 always reads 0; writes to R0 are discarded, but result still shows the computed value.
//  ALU arithmetic:
//   - Result is modulo 2^DATA_W. ADD = A+B+cmd_carry. SUB = A-B.
//   - SHL/SHR are logical shifts by B[log2(DATA_W)-1:0].
//  Flags:
//   - Z = (result==0); N = result MSB.
//   - C = carry-out for ADD; borrow (A<B unsigned) for SUB; 0 for other functions.
//   - V = signed overflow for ADD/SUB; 0 for other functions.
//   - Updated only by ALU mode.
//  LOAD: R[d] = RAM[addr]; result = loaded word.
//  STORE: RAM[addr] = R[d]; result = R[d]; no register write.
//  Address range: if alu result >= RAM_DEPTH, the MEM state performs no access.
//   - LOAD leaves R[d] unchanged and gives result=0.
//   - err=1 with done.
//   - err is cleared by the next LOAD/STORE done that has a valid address.
//  Hazards:
//   - sel_d may equal sel_a or sel_b: operands are read in READ, before WB.
//   - Back-to-back commands see the prior write, because the register write completes in WB
//     and the next READ happens at least 2 cycles later.
// TESTING
//  1 Reset, then LDI R3=5 -> done at T+1, result=5, R3=5; flags stay 0.
//  2 R1=0xFFFF..FF, R2=1, ALU ADD(1,2), carry=0 -> done at T+3, result=0, flags={V0,C1,N0,Z1}.
//  3 R4=0x10, R5=0x8, STORE d=R3 addr=ADD(4,5), then LOAD d=R6 same addr -> RAM[0x18]=5, R6=5,
//    err=0, each done at T+4.
//  4 R7=RAM_DEPTH, LOAD ADD(7,0) -> err=1, R[d] unchanged, result=0.
//    A following valid LOAD clears err.
//  5 LDI R0=9 -> result=9, R0 still reads 0.
//    With cmd_valid held high continuously, cmd_ready is 0 between accept and WB.
//  6 Drop rst mid-EXEC of an ALU write to R8 -> R8=0, outputs at reset values,
//    next command accepted normally.

Source files
------------

// File: rtl/datapath_sequencer.sv
// ============================================================================
// Module   : datapath_sequencer
// Brief    : Register-file / ALU / RAM datapath that sequences each accepted
//            command through READ, EXEC, MEM and WB on its own.
// Revision : 1.0
// ============================================================================
`default_nettype none

module datapath_sequencer #(
    parameter int DATA_W    = 64,
    parameter int REG_N     = 32,
    parameter int RAM_DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic [1:0]               i_cmd_mode,
    input  logic [2:0]               i_cmd_fn,
    input  logic                     i_cmd_carry,
    input  logic [$clog2(REG_N)-1:0] i_cmd_sel_a,
    input  logic [$clog2(REG_N)-1:0] i_cmd_sel_b,
    input  logic [$clog2(REG_N)-1:0] i_cmd_sel_d,
    input  logic [DATA_W-1:0]        i_cmd_imm,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [DATA_W-1:0]        o_result,
    output logic [3:0]               o_flags,
    output logic                     o_err
);

    localparam int RA_W = $clog2(REG_N);
    localparam int AW   = $clog2(RAM_DEPTH);
    localparam int SH_W = $clog2(DATA_W);

    localparam logic [1:0] c_ALU   = 2'd0;
    localparam logic [1:0] c_LOAD  = 2'd1;
    localparam logic [1:0] c_STORE = 2'd2;
    localparam logic [1:0] c_LDI   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_EXEC = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4
    } state_t;

    state_t              r_state;
    logic                r_ready;
    logic                r_done;
    logic                r_err;
    logic                r_wen;
    logic [3:0]          r_flags;
    logic [DATA_W-1:0]   r_result;
    logic [1:0]          r_mode;
    logic [2:0]          r_fn;
    logic                r_carry;
    logic [RA_W-1:0]     r_sel_a;
    logic [RA_W-1:0]     r_sel_b;
    logic [RA_W-1:0]     r_sel_d;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_dv;
    logic [DATA_W-1:0]   r_alu;
    logic [DATA_W-1:0]   r_regs [REG_N];
    logic [DATA_W-1:0]   r_ram  [RAM_DEPTH];

    logic [DATA_W-1:0]   w_alu;
    logic [3:0]          w_flags;
    logic [DATA_W-1:0]   w_sum;
    logic [DATA_W-1:0]   w_diff;
    logic                w_cout;
    logic                w_borrow;
    logic [SH_W-1:0]     w_shamt;
    logic [AW-1:0]       w_addr;
    logic                w_addr_ok;

    assign {w_cout, w_sum}    = {1'b0, r_a} + {1'b0, r_b} + {{DATA_W{1'b0}}, r_carry};
    assign {w_borrow, w_diff} = {1'b0, r_a} - {1'b0, r_b};
    assign w_shamt            = r_b[SH_W-1:0];

    always_comb begin
        w_alu   = '0;
        w_flags = '0;
        case (r_fn)
            3'd0: begin
                w_alu      = w_sum;
                w_flags[2] = w_cout;
                w_flags[3] = (r_a[DATA_W-1] == r_b[DATA_W-1]) && (w_sum[DATA_W-1] != r_a[DATA_W-1]);
            end
            3'd1: begin
                w_alu      = w_diff;
                w_flags[2] = w_borrow;
                w_flags[3] = (r_a[DATA_W-1] != r_b[DATA_W-1]) && (w_diff[DATA_W-1] != r_a[DATA_W-1]);
            end
            3'd2:    w_alu = r_a & r_b;
            3'd3:    w_alu = r_a | r_b;
            3'd4:    w_alu = r_a ^ r_b;
            3'd5:    w_alu = r_a << w_shamt;
            3'd6:    w_alu = r_a >> w_shamt;
            default: w_alu = r_b;
        endcase
        w_flags[1] = w_alu[DATA_W-1];
        w_flags[0] = (w_alu == '0);
    end

    // Any set bit at or above AW means the address lies beyond the RAM.
    assign w_addr    = r_alu[AW-1:0];
    assign w_addr_ok = ((r_alu >> AW) == {DATA_W{1'b0}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_wen    <= 1'b0;
            r_flags  <= '0;
            r_result <= '0;
            r_mode   <= '0;
            r_fn     <= '0;
            r_carry  <= 1'b0;
            r_sel_a  <= '0;
            r_sel_b  <= '0;
            r_sel_d  <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_dv     <= '0;
            r_alu    <= '0;
            for (int i = 0; i < REG_N; i++) r_regs[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_cmd_valid && r_ready) begin
                        r_mode  <= i_cmd_mode;
                        r_fn    <= i_cmd_fn;
                        r_carry <= i_cmd_carry;
                        r_sel_a <= i_cmd_sel_a;
                        r_sel_b <= i_cmd_sel_b;
                        r_sel_d <= i_cmd_sel_d;
                        r_ready <= 1'b0;
                        if (i_cmd_mode == c_LDI) begin
                            r_result <= i_cmd_imm;
                            r_wen    <= 1'b1;
                            r_done   <= 1'b1;
                            r_state  <= S_WB;
                        end else begin
                            r_state  <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    // R0 is never written, so a plain array read already returns 0.
                    r_a     <= r_regs[r_sel_a];
                    r_b     <= r_regs[r_sel_b];
                    r_dv    <= r_regs[r_sel_d];
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_alu <= w_alu;
                    if (r_mode == c_ALU) begin
                        r_result <= w_alu;
                        r_flags  <= w_flags;
                        r_wen    <= 1'b1;
                        r_done   <= 1'b1;
                        r_state  <= S_WB;
                    end else begin
                        r_state  <= S_MEM;
                    end
                end
                S_MEM: begin
                    r_done  <= 1'b1;
                    r_state <= S_WB;
                    if (w_addr_ok) begin
                        r_err    <= 1'b0;
                        r_wen    <= (r_mode == c_LOAD);
                        r_result <= (r_mode == c_LOAD) ? r_ram[w_addr] : r_dv;
                    end else begin
                        r_err    <= 1'b1;
                        r_wen    <= 1'b0;
                        r_result <= (r_mode == c_LOAD) ? '0 : r_dv;
                    end
                end
                S_WB: begin
                    if (r_wen && (r_sel_d != '0)) r_regs[r_sel_d] <= r_result;
                    r_wen   <= 1'b0;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_done  <= 1'b0;
                    r_wen   <= 1'b0;
                end
            endcase
        end
    end

    // RAM has no reset; a reset leaves the FSM outside MEM so no store lands.
    always_ff @(posedge clk) begin
        if ((r_state == S_MEM) && (r_mode == c_STORE) && w_addr_ok)
            r_ram[w_addr] <= r_dv;
    end

    assign o_cmd_ready = r_ready;
    assign o_busy      = ~r_ready;
    assign o_done      = r_done;
    assign o_result    = r_result;
    assign o_flags     = r_flags;
    assign o_err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_datapath_sequencer.sv
// ============================================================================
// Module   : tb_datapath_sequencer
// Brief    : Directed self-checking bench for datapath_sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_datapath_sequencer;

    localparam int DATA_W    = 64;
    localparam int REG_N     = 32;
    localparam int RAM_DEPTH = 256;

    localparam logic [1:0] c_ALU   = 2'd0;
    localparam logic [1:0] c_LOAD  = 2'd1;
    localparam logic [1:0] c_STORE = 2'd2;
    localparam logic [1:0] c_LDI   = 2'd3;

    localparam logic [2:0] c_ADD = 3'd0, c_SUB = 3'd1, c_SHL = 3'd5, c_SHR = 3'd6, c_PASSB = 3'd7;

    logic              clk;
    logic              rst_n;
    logic              i_cmd_valid;
    logic              o_cmd_ready;
    logic [1:0]        i_cmd_mode;
    logic [2:0]        i_cmd_fn;
    logic              i_cmd_carry;
    logic [4:0]        i_cmd_sel_a;
    logic [4:0]        i_cmd_sel_b;
    logic [4:0]        i_cmd_sel_d;
    logic [DATA_W-1:0] i_cmd_imm;
    logic              o_busy;
    logic              o_done;
    logic [DATA_W-1:0] o_result;
    logic [3:0]        o_flags;
    logic              o_err;

    int n_checks = 0;
    int n_pass   = 0;
    int lat;

    datapath_sequencer #(
        .DATA_W    (DATA_W),
        .REG_N     (REG_N),
        .RAM_DEPTH (RAM_DEPTH)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (o_cmd_ready),
        .i_cmd_mode  (i_cmd_mode),
        .i_cmd_fn    (i_cmd_fn),
        .i_cmd_carry (i_cmd_carry),
        .i_cmd_sel_a (i_cmd_sel_a),
        .i_cmd_sel_b (i_cmd_sel_b),
        .i_cmd_sel_d (i_cmd_sel_d),
        .i_cmd_imm   (i_cmd_imm),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_result    (o_result),
        .o_flags     (o_flags),
        .o_err       (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_ready();
        int guard = 0;
        @(negedge clk);
        while (!o_cmd_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!o_cmd_ready) chk("ready_timeout", 64'd0, 64'd1);
    endtask

    // Issues one command; lat = cycles from the accept edge to the done cycle.
    task automatic run_cmd(input logic [1:0] mode, input logic [2:0] fn, input logic carry,
                           input int a, input int b, input int d,
                           input logic [63:0] imm, input bit hold, output int lat_o);
        wait_ready();
        i_cmd_valid = 1'b1;
        i_cmd_mode  = mode;
        i_cmd_fn    = fn;
        i_cmd_carry = carry;
        i_cmd_sel_a = a[4:0];
        i_cmd_sel_b = b[4:0];
        i_cmd_sel_d = d[4:0];
        i_cmd_imm   = imm;
        @(posedge clk);
        #1;
        if (!hold) i_cmd_valid = 1'b0;
        lat_o = 0;
        for (int k = 1; k <= 20; k++) begin
            if (o_done) begin
                lat_o = k;
                break;
            end
            if (hold) chk("ready_while_busy", {63'd0, o_cmd_ready}, 64'd0);
            @(posedge clk);
            #1;
        end
        i_cmd_valid = 1'b0;
        if (lat_o == 0) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic ldi(input int d, input logic [63:0] imm);
        int l;
        run_cmd(c_LDI, 3'd0, 1'b0, 0, 0, d, imm, 1'b0, l);
    endtask

    // Reads a register back through PASSB into R0, which discards the write.
    task automatic peek(input string tag, input int b, input logic [63:0] exp);
        int l;
        run_cmd(c_ALU, c_PASSB, 1'b0, 0, b, 0, 64'd0, 1'b0, l);
        chk(tag, o_result, exp);
    endtask

    initial begin
        rst_n       = 1'b0;
        i_cmd_valid = 1'b0;
        i_cmd_mode  = '0;
        i_cmd_fn    = '0;
        i_cmd_carry = 1'b0;
        i_cmd_sel_a = '0;
        i_cmd_sel_b = '0;
        i_cmd_sel_d = '0;
        i_cmd_imm   = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready",  {63'd0, o_cmd_ready}, 64'd1);
        chk("rst_busy",   {63'd0, o_busy},      64'd0);
        chk("rst_done",   {63'd0, o_done},      64'd0);
        chk("rst_result", o_result,             64'd0);
        chk("rst_flags",  {60'd0, o_flags},     64'd0);
        chk("rst_err",    {63'd0, o_err},       64'd0);
        rst_n = 1'b1;

        // LDI
        run_cmd(c_LDI, 3'd0, 1'b0, 0, 0, 3, 64'd5, 1'b0, lat);
        chk("ldi_lat",    lat,              64'd1);
        chk("ldi_result", o_result,         64'd5);
        chk("ldi_flags",  {60'd0, o_flags}, 64'd0);
        peek("ldi_r3", 3, 64'd5);

        // ADD carry-out into zero
        ldi(1, 64'hFFFF_FFFF_FFFF_FFFF);
        ldi(2, 64'd1);
        run_cmd(c_ALU, c_ADD, 1'b0, 1, 2, 9, 64'd0, 1'b0, lat);
        chk("add_lat",    lat,              64'd3);
        chk("add_result", o_result,         64'd0);
        chk("add_flags",  {60'd0, o_flags}, 64'h5);

        // SUB with borrow: 1 - (-1) = 2
        run_cmd(c_ALU, c_SUB, 1'b0, 2, 1, 10, 64'd0, 1'b0, lat);
        chk("sub_result", o_result,         64'd2);
        chk("sub_flags",  {60'd0, o_flags}, 64'h4);

        // STORE then LOAD at 0x18
        ldi(4, 64'h10);
        ldi(5, 64'h8);
        run_cmd(c_STORE, c_ADD, 1'b0, 4, 5, 3, 64'd0, 1'b0, lat);
        chk("st_lat",    lat,            64'd4);
        chk("st_result", o_result,       64'd5);
        chk("st_err",    {63'd0, o_err}, 64'd0);
        run_cmd(c_LOAD, c_ADD, 1'b0, 4, 5, 6, 64'd0, 1'b0, lat);
        chk("ld_lat",    lat,            64'd4);
        chk("ld_result", o_result,       64'd5);
        chk("ld_err",    {63'd0, o_err}, 64'd0);
        peek("ld_r6", 6, 64'd5);
        chk("passb_flags", {60'd0, o_flags}, 64'h0);

        // Out-of-range LOAD, then a valid LOAD clears err
        ldi(7, 64'd256);
        run_cmd(c_LOAD, c_ADD, 1'b0, 7, 0, 6, 64'd0, 1'b0, lat);
        chk("oor_lat",    lat,            64'd4);
        chk("oor_err",    {63'd0, o_err}, 64'd1);
        chk("oor_result", o_result,       64'd0);
        peek("oor_r6_kept", 6, 64'd5);
        chk("oor_err_held", {63'd0, o_err}, 64'd1);
        run_cmd(c_LOAD, c_ADD, 1'b0, 4, 5, 10, 64'd0, 1'b0, lat);
        chk("clr_err",    {63'd0, o_err}, 64'd0);
        chk("clr_result", o_result,       64'd5);

        // Shifts, signed overflow, destination equal to source
        run_cmd(c_ALU, c_SHL, 1'b0, 4, 5, 12, 64'd0, 1'b0, lat);
        chk("shl_result", o_result, 64'h1000);
        ldi(11, 64'h7FFF_FFFF_FFFF_FFFF);
        run_cmd(c_ALU, c_SHR, 1'b0, 11, 5, 13, 64'd0, 1'b0, lat);
        chk("shr_result", o_result, 64'h007F_FFFF_FFFF_FFFF);
        run_cmd(c_ALU, c_ADD, 1'b0, 11, 2, 13, 64'd0, 1'b0, lat);
        chk("ovf_result", o_result,         64'h8000_0000_0000_0000);
        chk("ovf_flags",  {60'd0, o_flags}, 64'hA);
        run_cmd(c_ALU, c_ADD, 1'b1, 4, 5, 4, 64'd0, 1'b0, lat);
        chk("haz_result", o_result, 64'h19);
        peek("haz_r4", 4, 64'h19);

        // LDI to R0 with valid held high
        run_cmd(c_LDI, 3'd0, 1'b0, 0, 0, 0, 64'd9, 1'b1, lat);
        chk("r0_lat",    lat,      64'd1);
        chk("r0_result", o_result, 64'd9);
        run_cmd(c_ALU, c_PASSB, 1'b0, 0, 0, 0, 64'd0, 1'b1, lat);
        chk("r0_reads0", o_result,         64'd0);
        chk("r0_flags",  {60'd0, o_flags}, 64'h1);

        // Reset in the EXEC cycle of an ALU write to R8
        wait_ready();
        i_cmd_valid = 1'b1;
        i_cmd_mode  = c_ALU;
        i_cmd_fn    = c_ADD;
        i_cmd_carry = 1'b0;
        i_cmd_sel_a = 5'd4;
        i_cmd_sel_b = 5'd5;
        i_cmd_sel_d = 5'd8;
        @(posedge clk);
        #1;
        i_cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready",  {63'd0, o_cmd_ready}, 64'd1);
        chk("mid_rst_busy",   {63'd0, o_busy},      64'd0);
        chk("mid_rst_done",   {63'd0, o_done},      64'd0);
        chk("mid_rst_result", o_result,             64'd0);
        chk("mid_rst_flags",  {60'd0, o_flags},     64'd0);
        chk("mid_rst_err",    {63'd0, o_err},       64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        chk("post_rst_done", {63'd0, o_done}, 64'd0);
        peek("post_rst_r8", 8, 64'd0);
        peek("post_rst_r4", 4, 64'd0);
        run_cmd(c_LDI, 3'd0, 1'b0, 0, 0, 8, 64'h42, 1'b0, lat);
        chk("post_rst_lat", lat, 64'd1);
        peek("post_rst_r8_new", 8, 64'h42);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
